// File: rtl/apb_master_bridge.sv
// APB4 requester: turns a single-outstanding valid/ready command into one SETUP/ACCESS
// transfer and returns read data / error status. An ACCESS watchdog bounds slave waits.
`timescale 1ns/1ps
module apb_master_bridge #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        pclk,
  input  logic        preset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [11:2] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [11:2] paddr,
  output logic [31:0] pwdata,
  output logic [3:0]  pwstrb,
  input  logic [31:0] prdata,
  input  logic        pslverr,
  input  logic        pready
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               psel_q, psel_d;
  logic               penable_q, penable_d;
  logic               pwrite_q, pwrite_d;
  logic [11:2]        paddr_q, paddr_d;
  logic [31:0]        pwdata_q, pwdata_d;
  logic [3:0]         pwstrb_q, pwstrb_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic               timeout_hit_c;

  // The TIMEOUT-th consecutive not-ready ACCESS cycle; a ready slave in that cycle still wins.
  assign timeout_hit_c = (TIMEOUT != 0) && (state_q == ACCESS) && !pready &&
                         (wait_cnt_q == CNT_W'(TIMEOUT - 1));

  // State and output registers
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      cmd_ready_q   <= 1'b1;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwstrb_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pwstrb_q      <= pwstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready || timeout_hit_c) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; registered outputs are decoded from the next state
  always_comb begin
    wait_cnt_d    = wait_cnt_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwstrb_d      = pwstrb_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    cmd_ready_d = (state_d == IDLE);
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    rsp_valid_d = (state_d == RESP);

    if ((state_q == IDLE) && (state_d == SETUP)) begin
      pwrite_d   = cmd_write;
      paddr_d    = cmd_addr;
      pwdata_d   = cmd_write ? cmd_wdata : 32'd0;
      pwstrb_d   = cmd_write ? cmd_wstrb : 4'd0;
      wait_cnt_d = '0;
    end

    if (state_q == ACCESS) begin
      if (pready) begin
        rsp_rdata_d   = pwrite_q ? 32'd0 : prdata;
        rsp_err_d     = pslverr;
        rsp_timeout_d = 1'b0;
      end else begin
        if (wait_cnt_q != {CNT_W{1'b1}}) wait_cnt_d = wait_cnt_q + CNT_W'(1);
        if (timeout_hit_c) begin
          rsp_rdata_d   = 32'd0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end
      end
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pwstrb      = pwstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: random commands against a memory-backed APB slave,
// expected responses from a transaction-level model, checked by an independent monitor.
`timescale 1ns/1ps
module tb_apb_master_bridge;

  localparam int unsigned TO    = 4;
  localparam int          STUCK = 99;

  logic        pclk;
  logic        preset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [9:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [9:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pwstrb;
  logic [31:0] prdata;
  logic        pslverr, pready;

  typedef struct {
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          waits;
    logic        err;
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    int          lat;
    int          acc;
  } exp_t;

  plan_t       plan_q[$];
  exp_t        exp_q[$];
  logic [31:0] ref_mem [1024];
  logic [31:0] slv_mem [1024];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          hs_edge = -1;
  int          last_acc = 0;
  int          rr_mode = 2;
  bit          rst_abort = 0;

  apb_master_bridge #(.TIMEOUT(TO)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pwstrb(pwstrb), .prdata(prdata), .pslverr(pslverr),
    .pready(pready)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  always @(posedge pclk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic bit times_out(input plan_t p);
    return (TO != 0) && (p.waits >= int'(TO));
  endfunction

  function automatic int access_cycles(input plan_t p);
    return times_out(p) ? int'(TO) : p.waits + 1;
  endfunction

  // Transaction-level model: what the requester must report for this command
  function automatic exp_t model(input plan_t p);
    exp_t e;
    e.acc = 0;
    e.lat = access_cycles(p) + 2;
    if (times_out(p)) begin
      e.rdata = 32'd0; e.err = 1'b1; e.tmo = 1'b1;
    end else begin
      e.tmo   = 1'b0;
      e.err   = p.err;
      e.rdata = p.wr ? 32'd0 : ref_mem[p.addr];
      if (p.wr && !p.err)
        for (int b = 0; b < 4; b++)
          if (p.wstrb[b]) ref_mem[p.addr][8*b +: 8] = p.wdata[8*b +: 8];
    end
    return e;
  endfunction

  function automatic plan_t mk(input logic wr, input logic [9:0] a, input logic [31:0] d,
                               input logic [3:0] s, input int w, input logic e);
    plan_t p;
    p.wr = wr; p.addr = a; p.wdata = d; p.wstrb = s; p.waits = w; p.err = e;
    return p;
  endfunction

  function automatic plan_t rand_plan();
    plan_t p;
    int r;
    p.wr    = 1'($urandom_range(0, 1));
    r       = int'($urandom_range(0, 7));
    p.addr  = (r == 0) ? 10'h3FF : (r == 1) ? 10'h000 : 10'($urandom_range(0, 15));
    p.wdata = $urandom;
    p.wstrb = 4'($urandom);
    p.err   = ($urandom_range(0, 7) == 0);
    r       = int'($urandom_range(0, 9));
    if (r <= 3)      p.waits = 0;
    else if (r <= 6) p.waits = int'($urandom_range(1, 3));
    else if (r == 7) p.waits = int'(TO) - 1;
    else if (r == 8) p.waits = int'(TO);
    else             p.waits = STUCK;
    return p;
  endfunction

  // Present one command and hold it until the bridge takes it
  task automatic issue(input plan_t p, input bit expect_rsp);
    exp_t e;
    bit   got;
    if (expect_rsp) e = model(p);
    plan_q.push_back(p);
    cmd_write = p.wr; cmd_addr = p.addr; cmd_wdata = p.wdata; cmd_wstrb = p.wstrb;
    cmd_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge pclk);
      if (cmd_ready) got = 1'b1;
    end
    if (!got) check("cmd_accept", 32'd0, 32'd1);
    else begin
      last_acc = cyc;
      if (expect_rsp) begin
        e.acc = cyc;
        exp_q.push_back(e);
      end
    end
    @(posedge pclk);
    #1;
    cmd_valid = 1'b0;
    cmd_addr  = 10'($urandom);
    cmd_wdata = $urandom;
    cmd_wstrb = 4'($urandom);
    cmd_write = 1'($urandom);
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && (exp_q.size() != 0 || rsp_valid); k++) @(negedge pclk);
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    @(posedge pclk);
    #1;
  endtask

  task automatic bus_check(input plan_t p);
    check("paddr",  32'(paddr),  32'(p.addr));
    check("pwrite", 32'(pwrite), 32'(p.wr));
    check("pwdata", pwdata,      p.wr ? p.wdata : 32'd0);
    check("pwstrb", 32'(pwstrb), p.wr ? 32'(p.wstrb) : 32'd0);
  endtask

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge pclk);
      #1;
      case (rr_mode)
        0:       rsp_ready = ($urandom_range(0, 3) != 0);
        1:       rsp_ready = 1'b0;
        default: rsp_ready = 1'b1;
      endcase
    end
  end

  // APB slave: follows the per-command plan, backed by its own memory
  initial begin
    plan_t cur;
    int    acc_cnt;
    bit    in_xfer, was_setup;
    acc_cnt = 0; in_xfer = 0; was_setup = 0;
    pready = 1'b0; prdata = 32'd0; pslverr = 1'b0;
    forever begin
      @(negedge pclk);
      if (psel && !penable) begin
        if (plan_q.size() == 0) begin
          check("unexpected_setup", 32'd1, 32'd0);
          in_xfer = 0;
        end else begin
          cur = plan_q.pop_front();
          in_xfer = 1;
          bus_check(cur);
        end
        acc_cnt = 0; was_setup = 1;
        pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
      end else if (psel && penable) begin
        acc_cnt++;
        was_setup = 0;
        if (in_xfer) bus_check(cur);
        if (in_xfer && acc_cnt == cur.waits + 1) begin
          pready  = 1'b1;
          pslverr = cur.err;
          prdata  = cur.wr ? $urandom : slv_mem[paddr];
          if (cur.wr && !cur.err)
            for (int b = 0; b < 4; b++)
              if (pwstrb[b]) slv_mem[paddr][8*b +: 8] = pwdata[8*b +: 8];
        end else begin
          pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
        end
      end else begin
        if (was_setup && !rst_abort) check("setup_to_access", 32'd0, 32'd1);
        if (in_xfer && !rst_abort) check("access_cycles", 32'(acc_cnt), 32'(access_cycles(cur)));
        in_xfer = 0; was_setup = 0; acc_cnt = 0;
        pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
      end
    end
  end

  // Response monitor: pops the scoreboard on each new response, then checks it holds
  initial begin
    exp_t        e;
    logic [31:0] h_rdata;
    logic [1:0]  h_flags;
    bit          held;
    held = 0; h_rdata = 32'd0; h_flags = 2'd0;
    forever begin
      @(negedge pclk);
      if (!preset_n) held = 0;
      else if (rsp_valid) begin
        if (!held) begin
          if (exp_q.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            check("rsp_rdata",   rsp_rdata,          e.rdata);
            check("rsp_err",     32'(rsp_err),       32'(e.err));
            check("rsp_timeout", 32'(rsp_timeout),   32'(e.tmo));
            check("rsp_latency", 32'(cyc - e.acc),   32'(e.lat));
          end
          h_rdata = rsp_rdata;
          h_flags = {rsp_err, rsp_timeout};
        end else begin
          check("rsp_rdata_stable", rsp_rdata, h_rdata);
          check("rsp_flags_stable", 32'({rsp_err, rsp_timeout}), 32'(h_flags));
        end
        check("resp_bus_idle", 32'({psel, penable, cmd_ready}), 32'd0);
        if (rsp_ready) begin
          hs_edge = cyc;
          held = 0;
        end else held = 1;
      end
    end
  end

  initial begin
    int n_acc;
    preset_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    for (int i = 0; i < 1024; i++) begin
      slv_mem[i] = $urandom;
      ref_mem[i] = slv_mem[i];
    end
    slv_mem[10'h3FC] = 32'hDEADBEEF;
    ref_mem[10'h3FC] = 32'hDEADBEEF;

    repeat (2) @(posedge pclk);
    #1;
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_ctrl", 32'({psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout}), 32'd0);
    check("reset_paddr_pwstrb", 32'({paddr, pwstrb}), 32'd0);
    check("reset_pwdata", pwdata, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge pclk);
    preset_n = 1'b1;
    @(posedge pclk);
    #1;

    rr_mode = 2;
    issue(mk(1'b0, 10'h3FC, 32'h0, 4'hF, 0, 1'b0), 1'b1);
    drain();
    issue(mk(1'b1, 10'h010, 32'h12345678, 4'b0101, 3, 1'b0), 1'b1);
    drain();
    issue(mk(1'b0, 10'h3FC, 32'h0, 4'h0, 1, 1'b1), 1'b1);
    drain();
    issue(mk(1'b0, 10'h020, 32'h0, 4'h0, STUCK, 1'b0), 1'b1);
    drain();
    issue(mk(1'b1, 10'h020, 32'hA5A5C3C3, 4'b1111, int'(TO) - 1, 1'b0), 1'b1);
    drain();
    issue(mk(1'b0, 10'h010, 32'h0, 4'h0, 0, 1'b0), 1'b1);
    issue(mk(1'b0, 10'h020, 32'h0, 4'h0, 2, 1'b0), 1'b1);
    drain();

    rr_mode = 0;
    for (int t = 0; t < 150; t++) begin
      issue(rand_plan(), 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge pclk);
      #1;
    end
    rr_mode = 2;
    drain();

    // Response back-pressure with the next command already waiting
    rr_mode = 1;
    @(posedge pclk);
    #2;
    issue(mk(1'b0, 10'h3FC, 32'h0, 4'h0, 0, 1'b0), 1'b1);
    fork
      issue(mk(1'b1, 10'h005, 32'hCAFEF00D, 4'b1001, 0, 1'b0), 1'b1);
      begin
        for (int k = 0; k < 50 && !rsp_valid; k++) @(negedge pclk);
        check("bp_rsp_seen", 32'(rsp_valid), 32'd1);
        repeat (10) @(posedge pclk);
        rr_mode = 2;
      end
    join
    check("setup_after_handshake", 32'(last_acc - hs_edge), 32'd1);
    drain();

    // Reset in the second not-ready ACCESS cycle: no response may follow
    issue(mk(1'b0, 10'h007, 32'h0, 4'h0, STUCK, 1'b0), 1'b0);
    n_acc = 0;
    for (int k = 0; k < 20 && n_acc < 2; k++) begin
      @(negedge pclk);
      if (psel && penable) n_acc++;
    end
    check("rst_reached_access", 32'(n_acc), 32'd2);
    #1;
    rst_abort = 1;
    preset_n  = 1'b0;
    #1;
    check("rst_async_drop", 32'({psel, penable, rsp_valid}), 32'd0);
    @(negedge pclk);
    preset_n = 1'b1;
    @(posedge pclk);
    #1;
    check("rst_release_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_release_psel", 32'(psel), 32'd0);
    repeat (3) @(negedge pclk);
    rst_abort = 0;
    @(posedge pclk);
    #1;
    issue(mk(1'b0, 10'h3FC, 32'h0, 4'h0, 1, 1'b0), 1'b1);
    drain();
    repeat (4) @(posedge pclk);
    check("final_plan_queue", 32'(plan_q.size()), 32'd0);
    check("final_exp_queue", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
